// File: rtl/btn_step_debouncer_if.sv
// Button-side signal bundle for the step debouncer.
// The master drives the raw button and the enable.
// The slave (the debouncer) returns the conditioned outputs.
interface btn_step_debouncer_if;
   logic ena;
   logic btn_in;
   logic step_pulse;
   logic btn_level;
   logic repeating;

   modport master (
      output ena,
      output btn_in,
      input  step_pulse,
      input  btn_level,
      input  repeating
   );

   modport slave (
      input  ena,
      input  btn_in,
      output step_pulse,
      output btn_level,
      output repeating
   );
endinterface

// File: rtl/btn_step_debouncer.sv
// Push-button conditioner feeding a counter's count-enable input.
// The raw button passes through a two-flop synchroniser and is debounced.
// A press then produces one-cycle step pulses, and a held button auto-repeats.
// Deasserting ena clears the block exactly like reset, but the synchroniser keeps sampling.
module btn_step_debouncer #(
   parameter int DEB_CYCLES    = 16,
   parameter int REPEAT_DELAY  = 64,
   parameter int REPEAT_PERIOD = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   btn_step_debouncer_if.slave  bus
);

   localparam int MAX_A = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
   localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int CW    = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      PRESSED,
      REPEAT,
      DEB_RELEASE
   } state_t;

   state_t        state_q, state_d;
   logic          s1_q, s1_d, s2_q, s2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [CW-1:0] rcnt_q, rcnt_d;
   logic          pulse_q, pulse_d;
   logic          level_q, level_d;
   logic          rep_q, rep_d;
   logic          clear;

   // ena low is treated exactly like an active reset
   assign clear = !rst_n || !bus.ena;

   // synchroniser next values: the FSM only ever looks at s2
   always_comb begin
      s1_d = bus.btn_in;
      s2_d = s1_q;
   end

   // synchroniser flops run freely so a reset never loses the current button level
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
   end

   // state register
   always_ff @(posedge clk) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state logic: a change on s2 always wins over a terminal count
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (s2_q) state_d = DEB_PRESS;
         DEB_PRESS:   if (!s2_q) state_d = IDLE;
                      else if (cnt_q == DEB_LAST) state_d = PRESSED;
         PRESSED:     if (!s2_q) state_d = DEB_RELEASE;
                      else if (hcnt_q == DLY_LAST) state_d = REPEAT;
         REPEAT:      if (!s2_q) state_d = DEB_RELEASE;
         DEB_RELEASE: if (s2_q) state_d = PRESSED;
                      else if (cnt_q == DEB_LAST) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // counter and registered-output next values for each state
   always_comb begin
      cnt_d   = cnt_q;
      hcnt_d  = hcnt_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      level_d = level_q;
      rep_d   = rep_q;
      case (state_q)
         IDLE: begin
            if (s2_q) cnt_d = '0;
         end
         DEB_PRESS: begin
            if (s2_q) begin
               if (cnt_q == DEB_LAST) begin
                  hcnt_d  = '0;
                  pulse_d = 1'b1;
                  level_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end
         end
         PRESSED: begin
            if (!s2_q) begin
               cnt_d = '0;
            end else if (hcnt_q == DLY_LAST) begin
               rcnt_d  = '0;
               pulse_d = 1'b1;
               rep_d   = 1'b1;
            end else begin
               hcnt_d = hcnt_q + ONE;
            end
         end
         REPEAT: begin
            if (!s2_q) begin
               cnt_d = '0;
               rep_d = 1'b0;
            end else if (rcnt_q == PER_LAST) begin
               pulse_d = 1'b1;
               rcnt_d  = '0;
            end else begin
               rcnt_d = rcnt_q + ONE;
            end
         end
         DEB_RELEASE: begin
            // a bounce back high resumes the hold without a new pulse
            if (s2_q) begin
               hcnt_d = '0;
               rep_d  = 1'b0;
            end else if (cnt_q == DEB_LAST) begin
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // counters and registered outputs, cleared by reset or ena low
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q   <= '0;
         hcnt_q  <= '0;
         rcnt_q  <= '0;
         pulse_q <= 1'b0;
         level_q <= 1'b0;
         rep_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         hcnt_q  <= hcnt_d;
         rcnt_q  <= rcnt_d;
         pulse_q <= pulse_d;
         level_q <= level_d;
         rep_q   <= rep_d;
      end
   end

   assign bus.step_pulse = pulse_q;
   assign bus.btn_level  = level_q;
   assign bus.repeating  = rep_q;

endmodule

// File: tb/tb_btn_step_debouncer.sv
// Bench for btn_step_debouncer using default parameters (16/64/16).
// Expected pulse cycles and level samples are queued when stimulus is driven.
// A negedge monitor pops and compares them against the DUT outputs.
module tb_btn_step_debouncer;

   typedef struct {
      int   c;
      int   sel;
      logic v;
   } lvl_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   pq[$];
   lvl_t lq[$];
   logic chain_on = 1'b0;
   int   chain_cnt = 0;

   btn_step_debouncer_if bus ();

   btn_step_debouncer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic push_pulse(input int c);
      pq.push_back(c);
   endtask

   task automatic push_lvl(input int c, input int s, input logic v);
      lvl_t e;
      e.c   = c;
      e.sel = s;
      e.v   = v;
      lq.push_back(e);
   endtask

   // scoreboard monitor: sampled mid-cycle, cyc is the edge just taken
   always @(negedge clk) begin : mon
      int          tmp;
      string       tg;
      logic [31:0] act;
      lvl_t        keep[$];
      if (bus.step_pulse === 1'b1) begin
         if (pq.size() == 0) begin
            chk("pulse_unexpected", cyc, 0);
         end else begin
            tmp = pq.pop_front();
            chk("pulse_cycle", cyc, tmp);
         end
      end
      while (pq.size() > 0 && pq[0] < cyc) begin
         tmp = pq.pop_front();
         chk("pulse_missed", cyc, tmp);
      end
      keep = {};
      foreach (lq[i]) begin
         if (lq[i].c == cyc) begin
            case (lq[i].sel)
               0:       begin tg = "btn_level";  act = 32'(bus.btn_level);  end
               1:       begin tg = "repeating";  act = 32'(bus.repeating);  end
               default: begin tg = "step_pulse"; act = 32'(bus.step_pulse); end
            endcase
            chk(tg, act, 32'(lq[i].v));
         end else if (lq[i].c > cyc) begin
            keep.push_back(lq[i]);
         end
      end
      lq = keep;
   end

   // counter standing in for the downstream count-enable consumer
   always @(negedge clk) begin
      if (chain_on && bus.step_pulse === 1'b1) chain_cnt <= chain_cnt + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k, p, r, rr, rs, e;
      rst_n      = 1'b0;
      bus.ena    = 1'b1;
      bus.btn_in = 1'b0;
      repeat (4) tick();
      chk("reset_step_pulse", 32'(bus.step_pulse), 0);
      chk("reset_btn_level", 32'(bus.btn_level), 0);
      chk("reset_repeating", 32'(bus.repeating), 0);
      rst_n = 1'b1;
      repeat (5) tick();

      // clean press held into auto-repeat
      k = cyc + 1;
      p = k + 18;
      push_pulse(p);
      for (int i = 64; i <= 192; i += 16) push_pulse(p + i);
      push_lvl(p - 1, 0, 1'b0);
      push_lvl(p, 0, 1'b1);
      push_lvl(p, 1, 1'b0);
      push_lvl(p + 1, 2, 1'b0);
      push_lvl(p + 63, 1, 1'b0);
      push_lvl(p + 64, 1, 1'b1);
      push_lvl(p + 65, 2, 1'b0);
      bus.btn_in = 1'b1;
      wait_until(p + 200);

      // release from repeat
      r = cyc + 1;
      push_lvl(r + 1, 1, 1'b1);
      push_lvl(r + 2, 1, 1'b0);
      push_lvl(r + 17, 0, 1'b1);
      push_lvl(r + 18, 0, 1'b0);
      bus.btn_in = 1'b0;
      wait_until(r + 40);

      // re-press, then release with a 4-cycle bounce blip
      k = cyc + 1;
      push_pulse(k + 18);
      push_lvl(k + 18, 0, 1'b1);
      bus.btn_in = 1'b1;
      wait_until(k + 40);
      r = cyc + 1;
      push_lvl(r + 18, 0, 1'b1);
      push_lvl(r + 26, 0, 1'b1);
      push_lvl(r + 27, 0, 1'b0);
      bus.btn_in = 1'b0;
      wait_until(r + 4);
      bus.btn_in = 1'b1;
      wait_until(r + 8);
      bus.btn_in = 1'b0;
      wait_until(r + 40);
      chk("queue_after_repress", pq.size(), 0);

      // glitch of exactly DEB_CYCLES high samples: rejected
      k = cyc + 1;
      push_lvl(k + 18, 0, 1'b0);
      push_lvl(k + 20, 0, 1'b0);
      bus.btn_in = 1'b1;
      wait_until(k + 15);
      bus.btn_in = 1'b0;
      wait_until(k + 40);

      // DEB_CYCLES+1 high samples: accepted
      k = cyc + 1;
      push_pulse(k + 18);
      push_lvl(k + 18, 0, 1'b1);
      push_lvl(k + 34, 0, 1'b1);
      push_lvl(k + 35, 0, 1'b0);
      bus.btn_in = 1'b1;
      wait_until(k + 16);
      bus.btn_in = 1'b0;
      wait_until(k + 60);

      // bounce train: 5 high / 3 low
      for (int i = 0; i < 200; i++) begin
         bus.btn_in = ((i % 8) < 5);
         tick();
         chk("bounce_level", 32'(bus.btn_level), 0);
      end
      bus.btn_in = 1'b0;
      repeat (30) tick();

      // reset pulse while repeating
      k = cyc + 1;
      push_pulse(k + 18);
      push_pulse(k + 82);
      push_pulse(k + 98);
      bus.btn_in = 1'b1;
      wait_until(k + 100);
      rs = cyc + 1;
      push_lvl(rs, 0, 1'b0);
      push_lvl(rs, 1, 1'b0);
      push_lvl(rs, 2, 1'b0);
      push_lvl(rs + 16, 0, 1'b0);
      push_pulse(rs + 17);
      push_lvl(rs + 17, 0, 1'b1);
      push_lvl(rs + 17, 1, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_until(rs + 30);
      rr = cyc + 1;
      push_lvl(rr + 18, 0, 1'b0);
      bus.btn_in = 1'b0;
      wait_until(rr + 30);

      // ena low with the button held
      k = cyc + 1;
      push_pulse(k + 18);
      bus.btn_in = 1'b1;
      wait_until(k + 30);
      e = cyc + 1;
      push_lvl(e, 0, 1'b0);
      push_lvl(e, 1, 1'b0);
      push_lvl(e, 2, 1'b0);
      push_lvl(e + 50, 0, 1'b0);
      push_lvl(e + 116, 0, 1'b0);
      push_pulse(e + 117);
      push_lvl(e + 117, 0, 1'b1);
      bus.ena = 1'b0;
      wait_until(e + 100);
      bus.ena = 1'b1;
      wait_until(e + 130);
      rr = cyc + 1;
      push_lvl(rr + 18, 0, 1'b0);
      bus.btn_in = 1'b0;
      wait_until(rr + 30);

      // three clean presses counted downstream
      chain_on = 1'b1;
      for (int n = 0; n < 3; n++) begin
         k = cyc + 1;
         push_pulse(k + 18);
         bus.btn_in = 1'b1;
         wait_until(k + 25);
         bus.btn_in = 1'b0;
         wait_until(k + 70);
      end
      chain_on = 1'b0;
      tick();
      chk("chain_count", chain_cnt, 3);

      repeat (5) tick();
      chk("pulse_queue_empty", pq.size(), 0);
      chk("level_queue_empty", lq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
